// File: rtl/regmask_sequencer.sv
// regmask_sequencer: walks a PUSHM/POPM register mask, moving each selected
// register between the register file and memory over a classic bus and
// updating SP through the register file's SP write port.
module regmask_sequencer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned COUNTP = 4,
  parameter int unsigned SPREG  = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start,
  input  logic                  op,
  input  logic [2**COUNTP-1:0]  mask,
  output logic                  busy,
  output logic                  done,
  output logic [COUNTP-1:0]     rf_read_addr,
  input  logic [WIDTH-1:0]      rf_read_data,
  input  logic [WIDTH-1:0]      sp_i,
  output logic [COUNTP-1:0]     rf_write_addr,
  output logic [WIDTH-1:0]      rf_write_data,
  output logic [1:0]            rf_write_en,
  output logic [WIDTH-1:0]      rf_sp_data,
  output logic [1:0]            rf_sp_en,
  output logic                  bus_cyc,
  output logic                  bus_stb,
  output logic                  bus_we,
  output logic [WIDTH-1:0]      bus_adr,
  output logic [WIDTH-1:0]      bus_dat_o,
  input  logic [WIDTH-1:0]      bus_dat_i,
  input  logic                  bus_ack
);

  localparam int unsigned       COUNT  = 2 ** COUNTP;
  localparam logic [WIDTH-1:0]  STEP   = WIDTH'(4);
  localparam logic [COUNT-1:0]  SP_BIT = COUNT'(1) << SPREG;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_BUS,
    S_WB,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic [COUNT-1:0]   pending_q, pending_d;
  logic [COUNTP-1:0]  cur_q, cur_d;
  logic [WIDTH-1:0]   spr_q, spr_d;
  logic [WIDTH-1:0]   wdat_q, wdat_d;
  logic [WIDTH-1:0]   rdat_q, rdat_d;

  // Next values of every output; the flops below present them one cycle later
  logic               busy_d, done_d;
  logic [COUNTP-1:0]  wr_addr_d;
  logic [WIDTH-1:0]   wr_data_d, sp_data_d, adr_d, dato_d;
  logic [1:0]         wr_en_d, sp_en_d;
  logic               cyc_d, we_d;

  // Push walks the mask from the top, pop from the bottom
  function automatic logic [COUNTP-1:0] pick(input logic pop,
                                             input logic [COUNT-1:0] m);
    logic [COUNTP-1:0] sel;
    sel = '0;
    if (pop) begin
      for (int i = COUNT - 1; i >= 0; i--) begin
        if (m[i]) sel = COUNTP'(i);
      end
    end else begin
      for (int i = 0; i < COUNT; i++) begin
        if (m[i]) sel = COUNTP'(i);
      end
    end
    return sel;
  endfunction

  // Next-state, datapath and output look-ahead
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pending_d = pending_q;
    cur_d     = cur_q;
    spr_d     = spr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_en_d   = 2'h0;
    sp_data_d = '0;
    sp_en_d   = 2'h0;
    cyc_d     = 1'b0;
    we_d      = 1'b0;
    adr_d     = '0;
    dato_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          pending_d = mask & ~SP_BIT;
          spr_d     = sp_i;
          state_d   = (pending_d != '0) ? S_SETUP : S_DONE;
        end
      end
      S_SETUP: begin
        if (!op_q) wdat_d = rf_read_data;
        state_d = S_BUS;
      end
      S_BUS: begin
        if (bus_ack) begin
          if (op_q) rdat_d = bus_dat_i;
          state_d = S_WB;
        end
      end
      S_WB: begin
        spr_d     = op_q ? (spr_q + STEP) : (spr_q - STEP);
        pending_d = pending_q & ~(COUNT'(1) << cur_q);
        state_d   = (pending_d != '0) ? S_SETUP : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_SETUP) cur_d = pick(op_d, pending_d);

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    if (state_d == S_BUS) begin
      cyc_d  = 1'b1;
      we_d   = ~op_d;
      adr_d  = op_d ? spr_d : (spr_d - STEP);
      dato_d = op_d ? '0 : wdat_d;
    end

    if (state_d == S_WB) begin
      sp_en_d   = 2'h3;
      sp_data_d = op_d ? (spr_d + STEP) : (spr_d - STEP);
      if (op_d) begin
        wr_en_d   = 2'h3;
        wr_addr_d = cur_d;
        wr_data_d = rdat_d;
      end
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      op_q          <= 1'b0;
      pending_q     <= '0;
      cur_q         <= '0;
      spr_q         <= '0;
      wdat_q        <= '0;
      rdat_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rf_read_addr  <= '0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
      rf_write_en   <= 2'h0;
      rf_sp_data    <= '0;
      rf_sp_en      <= 2'h0;
      bus_cyc       <= 1'b0;
      bus_stb       <= 1'b0;
      bus_we        <= 1'b0;
      bus_adr       <= '0;
      bus_dat_o     <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      pending_q     <= pending_d;
      cur_q         <= cur_d;
      spr_q         <= spr_d;
      wdat_q        <= wdat_d;
      rdat_q        <= rdat_d;
      busy          <= busy_d;
      done          <= done_d;
      rf_read_addr  <= cur_d;
      rf_write_addr <= wr_addr_d;
      rf_write_data <= wr_data_d;
      rf_write_en   <= wr_en_d;
      rf_sp_data    <= sp_data_d;
      rf_sp_en      <= sp_en_d;
      bus_cyc       <= cyc_d;
      bus_stb       <= cyc_d;
      bus_we        <= we_d;
      bus_adr       <= adr_d;
      bus_dat_o     <= dato_d;
    end
  end

endmodule

// File: tb/tb_regmask_sequencer.sv
// Bench for regmask_sequencer: register-file, SP and memory slave models plus
// a transaction-level reference of PUSHM/POPM.
module tb_regmask_sequencer;

  logic        clk = 1'b0;
  logic        rst_i, start, op;
  logic [15:0] mask;
  logic        busy, done;
  logic [3:0]  rf_read_addr, rf_write_addr;
  logic [31:0] rf_read_data, sp_i, rf_write_data, rf_sp_data;
  logic [1:0]  rf_write_en, rf_sp_en;
  logic        bus_cyc, bus_stb, bus_we, bus_ack;
  logic [31:0] bus_adr, bus_dat_o, bus_dat_i;

  regmask_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .start(start), .op(op), .mask(mask),
    .busy(busy), .done(done), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .sp_i(sp_i), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .rf_sp_data(rf_sp_data), .rf_sp_en(rf_sp_en), .bus_cyc(bus_cyc),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
    .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment state
  logic [31:0] rf [16];
  logic [31:0] sp_reg;
  logic [31:0] mem [logic [31:0]];
  int          waits, wcnt, cyc, t0;
  int          done_cnt, done_cyc, busy_cnt, cyc_cnt, unstable;
  logic        prev_cyc, prev_we;
  logic [31:0] prev_adr, prev_dat;

  // Observed and expected transaction logs
  logic [31:0] bus_adr_q[$], bus_dat_q[$], bus_we_q[$];
  logic [31:0] rfw_addr_q[$], rfw_data_q[$], rfw_sp_q[$], sp_q[$];
  logic [31:0] e_adr_q[$], e_dat_q[$], e_we_q[$];
  logic [31:0] e_rfw_addr_q[$], e_rfw_data_q[$], e_sp_q[$];
  int          e_done;
  logic [31:0] e_sp_final;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hC0DE_0000 ^ a;
  endfunction

  // One clock: commit register-file / memory effects of this cycle, then
  // advance and present the slave responses for the next cycle
  task automatic tick();
    if (rf_write_en == 2'h3) begin
      rf[rf_write_addr] = rf_write_data;
      rfw_addr_q.push_back(32'(rf_write_addr));
      rfw_data_q.push_back(rf_write_data);
      rfw_sp_q.push_back(32'(rf_sp_en == 2'h3));
    end
    if (rf_sp_en == 2'h3) begin
      sp_reg = rf_sp_data;
      sp_q.push_back(rf_sp_data);
    end
    if (bus_cyc && bus_stb && bus_ack) begin
      bus_adr_q.push_back(bus_adr);
      bus_we_q.push_back(32'(bus_we));
      bus_dat_q.push_back(bus_we ? bus_dat_o : bus_dat_i);
      if (bus_we) mem[bus_adr] = bus_dat_o;
    end
    prev_cyc = bus_cyc; prev_we = bus_we; prev_adr = bus_adr; prev_dat = bus_dat_o;
    @(posedge clk);
    #1;
    cyc++;
    if (bus_cyc && prev_cyc &&
        (bus_adr !== prev_adr || bus_dat_o !== prev_dat || bus_we !== prev_we || bus_stb !== 1'b1))
      unstable++;
    rf_read_data = rf[rf_read_addr];
    sp_i = sp_reg;
    if (bus_cyc && bus_stb) begin
      if (wcnt == waits) begin
        bus_ack = 1'b1;
        bus_dat_i = mem_rd(bus_adr);
      end else begin
        bus_ack = 1'b0;
        bus_dat_i = $urandom;
        wcnt++;
      end
    end else begin
      bus_ack = 1'b0;
      bus_dat_i = $urandom;
      wcnt = 0;
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc - t0; end
    if (busy === 1'b1) busy_cnt++;
    if (bus_cyc === 1'b1) cyc_cnt++;
  endtask

  task automatic clear_logs();
    bus_adr_q.delete(); bus_dat_q.delete(); bus_we_q.delete();
    rfw_addr_q.delete(); rfw_data_q.delete(); rfw_sp_q.delete(); sp_q.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; cyc_cnt = 0; unstable = 0;
  endtask

  // Reference: the whole operation as a list of transfers
  task automatic model(input logic p_op, input logic [15:0] m, input logic [31:0] sp, input int w);
    logic [31:0] s, v;
    int n;
    e_adr_q.delete(); e_dat_q.delete(); e_we_q.delete();
    e_rfw_addr_q.delete(); e_rfw_data_q.delete(); e_sp_q.delete();
    s = sp; n = 0;
    if (!p_op) begin
      for (int r = 14; r >= 0; r--) begin
        if (m[r]) begin
          s = s - 32'd4;
          e_adr_q.push_back(s); e_dat_q.push_back(rf[r]); e_we_q.push_back(32'd1);
          e_sp_q.push_back(s);
          n++;
        end
      end
    end else begin
      for (int r = 0; r < 15; r++) begin
        if (m[r]) begin
          v = mem_rd(s);
          e_adr_q.push_back(s); e_dat_q.push_back(v); e_we_q.push_back(32'd0);
          e_rfw_addr_q.push_back(32'(r)); e_rfw_data_q.push_back(v);
          s = s + 32'd4;
          e_sp_q.push_back(s);
          n++;
        end
      end
    end
    e_sp_final = s;
    e_done = 1 + n * (3 + w);
  endtask

  task automatic run_op(input string tag, input logic p_op, input logic [15:0] m,
                        input logic [31:0] sp, input int w);
    int guard;
    model(p_op, m, sp, w);
    clear_logs();
    waits = w; sp_reg = sp; sp_i = sp;
    op = p_op; mask = m; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0; op = 1'($urandom); mask = 16'($urandom);
    guard = 0;
    while (done_cnt == 0 && guard < 300) begin tick(); guard++; end
    tick();
    check({tag, "/busy_after"}, 64'(busy), 64'd0);
    check({tag, "/done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "/done_cyc"}, 64'(done_cyc), 64'(e_done));
    check({tag, "/busy_cyc"}, 64'(busy_cnt), 64'(e_done));
    check({tag, "/cyc_cnt"}, 64'(cyc_cnt), 64'(e_adr_q.size() * (1 + w)));
    check({tag, "/unstable"}, 64'(unstable), 64'd0);
    check({tag, "/n_bus"}, 64'(bus_adr_q.size()), 64'(e_adr_q.size()));
    for (int i = 0; i < e_adr_q.size(); i++) begin
      check({tag, "/bus_adr"}, 64'(q_at(bus_adr_q, i)), 64'(e_adr_q[i]));
      check({tag, "/bus_dat"}, 64'(q_at(bus_dat_q, i)), 64'(e_dat_q[i]));
      check({tag, "/bus_we"}, 64'(q_at(bus_we_q, i)), 64'(e_we_q[i]));
    end
    check({tag, "/n_rfw"}, 64'(rfw_addr_q.size()), 64'(e_rfw_addr_q.size()));
    for (int i = 0; i < e_rfw_addr_q.size(); i++) begin
      check({tag, "/rfw_addr"}, 64'(q_at(rfw_addr_q, i)), 64'(e_rfw_addr_q[i]));
      check({tag, "/rfw_data"}, 64'(q_at(rfw_data_q, i)), 64'(e_rfw_data_q[i]));
      check({tag, "/rfw_with_sp"}, 64'(q_at(rfw_sp_q, i)), 64'd1);
    end
    check({tag, "/n_sp"}, 64'(sp_q.size()), 64'(e_sp_q.size()));
    for (int i = 0; i < e_sp_q.size(); i++)
      check({tag, "/sp_data"}, 64'(q_at(sp_q, i)), 64'(e_sp_q[i]));
    check({tag, "/sp_final"}, 64'(sp_reg), 64'(e_sp_final));
  endtask

  initial begin
    logic [31:0] base;
    cyc = 0; t0 = 0; waits = 0; wcnt = 0; sp_reg = '0;
    rst_i = 1'b1; start = 1'b0; op = 1'b0; mask = '0; sp_i = '0;
    bus_ack = 1'b0; bus_dat_i = '0; rf_read_data = '0;
    prev_cyc = 1'b0; prev_we = 1'b0; prev_adr = '0; prev_dat = '0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h100 + 32'(i);
    clear_logs();

    // Reset state
    tick(); tick();
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/bus_ctl", 64'({bus_cyc, bus_stb, bus_we}), 64'd0);
    check("rst/bus_adr", 64'(bus_adr), 64'd0);
    check("rst/bus_dat_o", 64'(bus_dat_o), 64'd0);
    check("rst/rf_en", 64'({rf_write_en, rf_sp_en}), 64'd0);
    check("rst/rf_data", 64'({rf_write_data, rf_sp_data}), 64'd0);
    check("rst/rf_addr", 64'({rf_write_addr, rf_read_addr}), 64'd0);
    rst_i = 1'b0;
    tick();

    // Push r2,r1 from SP 0x1000
    rf[1] = 32'h11; rf[2] = 32'h22;
    run_op("push6", 1'b0, 16'h0006, 32'h1000, 0);
    check("push6/done7", 64'(done_cyc), 64'd7);
    check("push6/adr0", 64'(q_at(bus_adr_q, 0)), 64'h0FFC);
    check("push6/dat0", 64'(q_at(bus_dat_q, 0)), 64'h22);
    check("push6/adr1", 64'(q_at(bus_adr_q, 1)), 64'h0FF8);
    check("push6/dat1", 64'(q_at(bus_dat_q, 1)), 64'h11);

    // Pop r1,r2 from SP 0xFF8
    mem[32'hFF8] = 32'hAA; mem[32'hFFC] = 32'hBB;
    rf[1] = 32'h0; rf[2] = 32'h0;
    run_op("pop6", 1'b1, 16'h0006, 32'h0FF8, 0);
    check("pop6/r1", 64'(rf[1]), 64'hAA);
    check("pop6/r2", 64'(rf[2]), 64'hBB);
    check("pop6/sp", 64'(sp_reg), 64'h1000);
    check("pop6/done7", 64'(done_cyc), 64'd7);

    // Empty effective masks
    run_op("spreg_only", 1'b0, 16'h8000, 32'h2000, 0);
    check("spreg_only/done1", 64'(done_cyc), 64'd1);
    run_op("empty", 1'b1, 16'h0000, 32'h2000, 0);
    check("empty/done1", 64'(done_cyc), 64'd1);

    // Slow slave
    run_op("push_wait3", 1'b0, 16'h0001, 32'h3000, 3);
    check("push_wait3/done7", 64'(done_cyc), 64'd7);
    check("push_wait3/cyc4", 64'(cyc_cnt), 64'd4);

    // SP wrap
    rf[0] = 32'h5A;
    run_op("wrap", 1'b0, 16'h0001, 32'h0, 0);
    check("wrap/adr", 64'(q_at(bus_adr_q, 0)), 64'hFFFF_FFFC);
    check("wrap/dat", 64'(q_at(bus_dat_q, 0)), 64'h5A);
    check("wrap/sp", 64'(q_at(sp_q, 0)), 64'hFFFF_FFFC);

    // Ignored start during BUS, then reset in the second transfer's BUS phase
    clear_logs();
    rf[1] = 32'h711; rf[2] = 32'h722;
    waits = 2; sp_reg = 32'h2000; sp_i = sp_reg;
    op = 1'b0; mask = 16'h0006; start = 1'b1; t0 = cyc;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = 1'b1; mask = 16'hFFFF;
    tick();
    start = 1'b0;
    while (cyc - t0 < 8) tick();
    check("rstmid/in_bus", 64'(bus_cyc), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rstmid/busy", 64'(busy), 64'd0);
    check("rstmid/bus_cyc", 64'({bus_cyc, bus_stb}), 64'd0);
    check("rstmid/rf_en", 64'({rf_write_en, rf_sp_en}), 64'd0);
    repeat (3) tick();
    check("rstmid/done_cnt", 64'(done_cnt), 64'd0);
    check("rstmid/n_sp", 64'(sp_q.size()), 64'd1);
    check("rstmid/sp0", 64'(q_at(sp_q, 0)), 64'h1FFC);
    check("rstmid/n_bus", 64'(bus_adr_q.size()), 64'd1);
    check("rstmid/dat0", 64'(q_at(bus_dat_q, 0)), 64'h722);
    check("rstmid/busy_cnt", 64'(busy_cnt), 64'd8);

    // Randomised operations, back to back
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 16; i++) rf[i] = $urandom;
      base = $urandom & 32'hFFFF_FFFC;
      for (int i = 0; i < 16; i++) mem[base + 32'(4 * i)] = $urandom;
      run_op($sformatf("rnd%0d", k), 1'($urandom), 16'($urandom), base,
             int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regmask_sequencer.md
# regmask_sequencer

Multi-register push/pop sequencer for the bexkat1 core. On a PUSHM/POPM instruction it walks a register mask, moving each selected register between the register file and memory over a single-master classic bus, and updates the stack pointer through the register file's dedicated SP write port. It owns one read port, the general write port and the SP port of the register file for the duration of the operation. Supervisor/user stack selection is the register file's job; this block only sees "current SP".

## Interface
- WIDTH, 32, data/address width
- COUNTP, 4, register address bits; COUNT = 2**COUNTP
- SPREG, 4'd15, stack pointer register index; its mask bit is always ignored
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- start  in  1  begin operation; honoured only in IDLE
- op  in  1  0 = push, 1 = pop; captured on start
- mask  in  COUNT  registers to transfer; captured on start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of operation
- rf_read_addr  out  COUNTP  register file read address
- rf_read_data  in  WIDTH  register file read data
- sp_i  in  WIDTH  current SP from register file; sampled on start
- rf_write_addr  out  COUNTP  general write address
- rf_write_data  out  WIDTH  general write data
- rf_write_en  out  2  2'h3 = word write, else 2'h0
- rf_sp_data  out  WIDTH  SP write data
- rf_sp_en  out  2  2'h3 = SP write, else 2'h0
- bus_cyc, bus_stb, bus_we  out  1  bus cycle, strobe, write enable
- bus_adr  out  WIDTH  byte address
- bus_dat_o  out  WIDTH  write data
- bus_dat_i  in  WIDTH  read data
- bus_ack  in  1  transfer acknowledge

## Operation
- States: IDLE, SETUP, BUS, WB, DONE.
- IDLE: on start, latch op, mask with bit SPREG cleared into `pending`, sp_i into `spr`. Next state is SETUP if `pending` != 0, else DONE.
- Register selection: push takes the highest set bit of `pending`; pop takes the lowest. Result is `cur`, registered in SETUP.
- SETUP (1 cycle): rf_read_addr = cur. For push, latch rf_read_data into `wdat` at cycle end. Go to BUS.
- BUS: bus_cyc = bus_stb = 1.
  - Push: bus_we = 1, bus_adr = spr-4, bus_dat_o = wdat.
  - Pop: bus_we = 0, bus_adr = spr.
  - All outputs held stable until bus_ack. On the ack cycle, pop latches bus_dat_i into `rdat`. Go to WB.
- WB (1 cycle):
  - Push: rf_sp_en = 3, rf_sp_data = spr-4, spr <= spr-4.
  - Pop: rf_write_en = 3, rf_write_addr = cur, rf_write_data = rdat; in the same cycle rf_sp_en = 3, rf_sp_data = spr+4, spr <= spr+4.
  - Clear bit cur in `pending`. Next state is SETUP if `pending` != 0, else DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Resulting memory layout: push stores the highest register at the highest address; pop restores in the mirror order.
- Arithmetic is modulo 2^WIDTH: SP wraps without error (push at SP=0 writes 0xFFFFFFFC).
- start outside IDLE is ignored. bus_ack outside BUS is ignored.
- All rf_* enables and bus_* controls are 0 outside the states above.
- rf_read_addr = cur in all states; its value matters only in SETUP.

## Timing
- Reset (rst_i high at clk edge): state IDLE, busy = done = 0, all bus_* = 0, rf_write_en = rf_sp_en = 0. All address/data outputs and internal registers are 0.
- Reset mid-operation: returns to IDLE next edge. The bus cycle is dropped, no further register writes occur, done is not pulsed. Completed writes are not undone.
- With start at cycle 0:
  - The first state is visible at cycle 1.
  - Zero-wait bus (ack in first BUS cycle) costs 3 cycles per register; done occurs at cycle 1+3N for N selected registers.
  - Each bus wait cycle adds 1.
  - An empty mask, or SPREG only, gives done at cycle 1 with no bus or register activity.
- busy is high from cycle 1 through the DONE cycle inclusive.
- A new start may be accepted in the cycle after DONE.

## Test plan
- Push, mask 0x0006, sp_i = 0x1000, r1 = 0x11, r2 = 0x22, zero-wait ack -> bus writes 0xFFC<-0x22 then 0xFF8<-0x11; rf_sp_en writes 0xFFC then 0xFF8; no rf_write_en; done at cycle 7.
- Pop, mask 0x0006, sp_i = 0xFF8, memory 0xFF8 = 0xAA, 0xFFC = 0xBB -> r1 <= 0xAA, r2 <= 0xBB, each write in the same cycle as an SP write (0xFFC, then 0x1000); done at cycle 7.
- Mask 0x8000 (SPREG only) and mask 0x0000 -> done at cycle 1, busy high only in cycle 1, no bus_cyc, no rf enables.
- Push, mask 0x0001, ack delayed 3 cycles -> stb/adr/dat_o/we stable for 4 BUS cycles; done at cycle 7.
- start pulsed during BUS is ignored; rst_i asserted during the second BUS cycle of a 2-register push -> next cycle IDLE, bus_cyc = 0, only the first SP write has occurred, no done.
- Push, mask 0x0001, sp_i = 0x0, r0 = 0x5A -> bus_adr = 0xFFFFFFFC, dat_o = 0x5A, rf_sp_data = 0xFFFFFFFC.
